stats_readout_ctrl: RTL

Sequences readout of the CPU instruction-statistics counters (I-type, R-type, J-type, clock count) onto a shared byte-wide valid/ready stream, such as the UART TX or debug link.
- On a start request it snapshots all four counters in one cycle, then emits a fixed-length frame byte by byte.
- Sits between the statistics counters and the byte-sink, and owns the sink while busy.

---
 rtl/stats_pkg.sv | 23 ++
 rtl/stats_frame_mux.sv | 55 +++++
 rtl/stats_readout_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stats_pkg
// Description : Shared definitions for the instruction-statistics readout
//               block: FSM state encoding, frame length, default header byte
//               and frame index width.
// Revision    : 1.0 - initial release
// ============================================================================
package stats_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // Header + four big-endian 16-bit counters
    localparam int         FRAME_LEN_BASE   = 9;
    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
    localparam int         IDX_W            = 4;

endpackage
`default_nettype wire

// File: rtl/stats_frame_mux.sv
`default_nettype none
// ============================================================================
// Module      : stats_frame_mux
// Description : Combinational selection of one frame byte from the frame
//               index and the four 16-bit shadow registers. Keeps byte
//               ordering separate from the handshake FSM.
// Ports       : i_idx      - frame byte index (0 = header)
//               i_shd_i/r/j/clk - snapshot registers, zero-extended to 16 bits
//               o_byte     - selected frame byte
// Config      : STATS_CKSUM_EN adds index 9 = XOR of the eight counter bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module stats_frame_mux
    import stats_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic [IDX_W-1:0] i_idx,
    input  logic [15:0]      i_shd_i,
    input  logic [15:0]      i_shd_r,
    input  logic [15:0]      i_shd_j,
    input  logic [15:0]      i_shd_clk,
    output logic [7:0]       o_byte
);

`ifdef STATS_CKSUM_EN
    // Header is deliberately excluded from the checksum
    logic [7:0] w_cksum;
    assign w_cksum = i_shd_i[15:8]   ^ i_shd_i[7:0]
                   ^ i_shd_r[15:8]   ^ i_shd_r[7:0]
                   ^ i_shd_j[15:8]   ^ i_shd_j[7:0]
                   ^ i_shd_clk[15:8] ^ i_shd_clk[7:0];
`endif

    always_comb begin
        o_byte = 8'h00;
        case (i_idx)
            4'd0:    o_byte = HDR_BYTE;
            4'd1:    o_byte = i_shd_i[15:8];
            4'd2:    o_byte = i_shd_i[7:0];
            4'd3:    o_byte = i_shd_r[15:8];
            4'd4:    o_byte = i_shd_r[7:0];
            4'd5:    o_byte = i_shd_j[15:8];
            4'd6:    o_byte = i_shd_j[7:0];
            4'd7:    o_byte = i_shd_clk[15:8];
            4'd8:    o_byte = i_shd_clk[7:0];
`ifdef STATS_CKSUM_EN
            4'd9:    o_byte = w_cksum;
`endif
            default: o_byte = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/stats_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stats_readout_ctrl
// Description : On a start request, snapshots the four statistics counters
//               and streams a fixed-length byte frame over a valid/ready
//               interface (header, then each counter big-endian).
// Ports       : clk, reset (async, active-high)
//               start                      - frame request, accepted in IDLE
//               i_cnt, r_cnt, j_cnt, clk_cnt - counter inputs (CNT_W bits)
//               tx_data, tx_valid, tx_ready - byte stream to the sink
//               busy                        - frame in progress
//               done                        - one-cycle pulse after last byte
// Config      : STATS_CKSUM_EN appends an XOR checksum byte (10-byte frame).
// Revision    : 1.0 - initial release
// ============================================================================
module stats_readout_ctrl
    import stats_pkg::*;
#(
    parameter int         CNT_W    = 11,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] r_cnt,
    input  logic [CNT_W-1:0] j_cnt,
    input  logic [CNT_W-1:0] clk_cnt,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done
);

`ifdef STATS_CKSUM_EN
    localparam int c_FRAME_LEN = FRAME_LEN_BASE + 1;
`else
    localparam int c_FRAME_LEN = FRAME_LEN_BASE;
`endif
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(c_FRAME_LEN - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [15:0]      r_shd_i;
    logic [15:0]      r_shd_r;
    logic [15:0]      r_shd_j;
    logic [15:0]      r_shd_clk;
    logic [7:0]       r_tx_data;

    logic             w_accept;
    logic             w_xfer;
    logic             w_last;
    logic [IDX_W-1:0] w_mux_idx;
    logic [7:0]       w_mux_byte;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_xfer   = (r_state == ST_SEND) && tx_ready;
    assign w_last   = (r_idx == c_LAST_IDX);

    // tx_data is preloaded one byte ahead: the mux looks at the byte that
    // becomes current after this edge, so the output itself is a flop.
    assign w_mux_idx = (r_state == ST_IDLE) ? '0 : r_idx + 1'b1;

    stats_frame_mux #(
        .HDR_BYTE (HDR_BYTE)
    ) u_frame_mux (
        .i_idx     (w_mux_idx),
        .i_shd_i   (r_shd_i),
        .i_shd_r   (r_shd_r),
        .i_shd_j   (r_shd_j),
        .i_shd_clk (r_shd_clk),
        .o_byte    (w_mux_byte)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_valid    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                if (tx_ready && w_last) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_shd_i   <= '0;
            r_shd_r   <= '0;
            r_shd_j   <= '0;
            r_shd_clk <= '0;
            r_tx_data <= '0;
        end else if (w_accept) begin
            // Coherent snapshot of all four counters in one edge
            r_shd_i   <= 16'(i_cnt);
            r_shd_r   <= 16'(r_cnt);
            r_shd_j   <= 16'(j_cnt);
            r_shd_clk <= 16'(clk_cnt);
            r_idx     <= '0;
            r_tx_data <= w_mux_byte;
        end else if (w_xfer) begin
            if (w_last) begin
                r_idx     <= '0;
                r_tx_data <= 8'h00;
            end else begin
                r_idx     <= r_idx + 1'b1;
                r_tx_data <= w_mux_byte;
            end
        end
    end

    assign tx_data = r_tx_data;

endmodule
`default_nettype wire
